// File: rtl/scan_mux_reg_pkg.sv
// Shared part-model package: mode encoding and select-width helper.
package scan_mux_reg_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 32'd2) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/scan_mux_seq.sv
// Scan sequencer: channel/dwell counters, stall handling, mode-change clearing.
// Ports:
//   clk, reset      clock, async active-high reset
//   en              block enable (inverse of enb_n)
//   mode            0 = direct, 1 = scan
//   y_valid         current registered valid flag of the output stage
//   y_ready         consumer accepts the current sample
//   ch              channel to sample next in scan mode
//   capture_c       this edge captures din[ch] into the output registers
//   mode_chg_c      this edge is the first one with a new mode
module scan_mux_seq
  import scan_mux_reg_pkg::*;
#(
  parameter  int unsigned NCH   = 2,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SELW  = sel_width(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            mode,
  input  logic            y_valid,
  input  logic            y_ready,
  output logic [SELW-1:0] ch,
  output logic            capture_c,
  output logic            mode_chg_c
);

  localparam int unsigned     DW      = sel_width(DWELL);
  localparam logic [DW-1:0]   D_LAST  = DW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST = SELW'(NCH - 1);

  logic [DW-1:0] d;
  logic          mode_q;
  logic          mode_known;
  logic          at_last;

  // mode_known suppresses a spurious mode change on the first edge after reset,
  // so a scan started straight out of reset still sees a full DWELL.
  assign mode_chg_c = en && mode_known && (mode != mode_q);
  assign at_last    = (d == D_LAST);
  assign capture_c  = en && !mode_chg_c && (mode == MODE_SCAN) && at_last
                      && (!y_valid || y_ready);

  // Counter update; a stalled sample holds both ch and d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch         <= '0;
      d          <= '0;
      mode_q     <= MODE_DIRECT;
      mode_known <= 1'b0;
    end else if (en) begin
      mode_q     <= mode;
      mode_known <= 1'b1;
      if (mode_chg_c) begin
        ch <= '0;
        d  <= '0;
      end else if (mode == MODE_SCAN) begin
        if (!at_last) begin
          d <= d + 1'b1;
        end else if (capture_c) begin
          d  <= '0;
          ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel data selector with latched select, optional inversion,
// emulated output enable and an auto-scan mode with valid/ready output.
// Ports:
//   clk, reset  clock, async active-high reset
//   din         NCH channels, channel k at [k*WIDTH +: WIDTH]
//   sel, load   direct-mode select and its latch strobe
//   enb_n       active-low enable; high freezes the block and drops y_oe
//   mode        0 = direct, 1 = scan
//   y_ready     consumer accepts the current sample (scan mode)
//   y, y_ch     registered sample and the channel it came from
//   y_oe        registered output-enable flag
//   y_valid     y holds a fresh sample
module scan_mux_reg
  import scan_mux_reg_pkg::*;
#(
  parameter  int unsigned WIDTH  = 4,
  parameter  int unsigned NCH    = 2,
  parameter  int unsigned DWELL  = 4,
  parameter  bit          INVERT = 1'b0,
  localparam int unsigned SELW   = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 load,
  input  logic                 enb_n,
  input  logic                 mode,
  input  logic                 y_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 y_oe,
  output logic [SELW-1:0]      y_ch,
  output logic                 y_valid
);

  logic             en;
  logic [SELW-1:0]  sel_q;
  logic [SELW-1:0]  scan_ch;
  logic [SELW-1:0]  src_ch;
  logic             capture_c;
  logic             mode_chg_c;
  logic [WIDTH-1:0] chan [NCH];
  logic [WIDTH-1:0] pick;

  assign en = !enb_n;

  // Unpack the flat channel bus.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[k] = din[k*WIDTH +: WIDTH];
  end

  // Inversion sits before the register so the reset value stays zero.
  assign src_ch = (mode == MODE_SCAN) ? scan_ch : sel_q;
  assign pick   = INVERT ? ~chan[src_ch] : chan[src_ch];

  scan_mux_seq #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .ch         (scan_ch),
    .capture_c  (capture_c),
    .mode_chg_c (mode_chg_c)
  );

  // Select latch and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      y       <= '0;
      y_oe    <= 1'b0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      y_oe <= en;
      if (en) begin
        // Out-of-range selects are dropped so sel_q always names a real channel.
        if (load && (32'(sel) < NCH)) sel_q <= sel;
        if (mode_chg_c) begin
          y_valid <= 1'b0;
        end else if (mode == MODE_DIRECT) begin
          y       <= pick;
          y_ch    <= sel_q;
          y_valid <= 1'b1;
        end else if (capture_c) begin
          y       <= pick;
          y_ch    <= scan_ch;
          y_valid <= 1'b1;
        end else if (y_ready) begin
          y_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_mux_reg.sv
// Directed bench for scan_mux_reg: main build (4x4, DWELL=3), an inverting
// build and a 3-channel build share the same stimulus.
module tb_scan_mux_reg;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [1:0]  sel;
  logic        load;
  logic        enb_n;
  logic        mode;
  logic        y_ready;

  logic [3:0]  y,   y_i,   y_3;
  logic        oe,  oe_i,  oe_3;
  logic [1:0]  ch,  ch_i,  ch_3;
  logic        vld, vld_i, vld_3;

  int n_chk  = 0;
  int n_pass = 0;

  scan_mux_reg #(.WIDTH(4), .NCH(4), .DWELL(3), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .load(load),
    .enb_n(enb_n), .mode(mode), .y_ready(y_ready),
    .y(y), .y_oe(oe), .y_ch(ch), .y_valid(vld)
  );

  scan_mux_reg #(.WIDTH(4), .NCH(4), .DWELL(3), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .load(load),
    .enb_n(enb_n), .mode(mode), .y_ready(y_ready),
    .y(y_i), .y_oe(oe_i), .y_ch(ch_i), .y_valid(vld_i)
  );

  scan_mux_reg #(.WIDTH(4), .NCH(3), .DWELL(3), .INVERT(1'b0)) dut3 (
    .clk(clk), .reset(reset), .din(din[11:0]), .sel(sel), .load(load),
    .enb_n(enb_n), .mode(mode), .y_ready(y_ready),
    .y(y_3), .y_oe(oe_3), .y_ch(ch_3), .y_valid(vld_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enb_n = 1'b1; mode = 1'b0; load = 1'b0;
    sel = 2'd0; y_ready = 1'b0; din = '0;

    // 1. reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      #3;
      din  = 16'($urandom);
      sel  = 2'(i);
      load = i[0];
      mode = ~i[0];
      enb_n = i[1];
      tick();
    end
    chk("rst_y",     32'(y),     32'h0);
    chk("rst_oe",    32'(oe),    32'h0);
    chk("rst_ch",    32'(ch),    32'h0);
    chk("rst_valid", 32'(vld),   32'h0);
    chk("rst_y_inv", 32'(y_i),   32'h0);
    chk("rst_y_n3",  32'(y_3),   32'h0);

    mode = 1'b0; load = 1'b0; sel = 2'd0; din = 16'h00A5;
    reset = 1'b0; enb_n = 1'b0;
    tick();
    chk("rel_oe",    32'(oe),  32'h1);
    chk("rel_y",     32'(y),   32'h5);
    chk("rel_valid", 32'(vld), 32'h1);

    // 2. direct mode, select latency of two edges
    load = 1'b1; sel = 2'd1;
    tick();
    load = 1'b0;
    chk("dir_lat1_y", 32'(y), 32'h5);
    tick();
    chk("dir_y",     32'(y),   32'hA);
    chk("dir_ch",    32'(ch),  32'h1);
    chk("dir_y_inv", 32'(y_i), 32'h5);
    chk("dir_y_n3",  32'(y_3), 32'hA);

    load = 1'b1; sel = 2'd3;
    tick();
    load = 1'b0;
    tick();
    chk("n3_ign_y",  32'(y_3),  32'hA);
    chk("n3_ign_ch", 32'(ch_3), 32'h1);
    chk("sel3_y",    32'(y),    32'h0);
    chk("sel3_ch",   32'(ch),   32'h3);
    din = 16'h70A5;
    tick();
    chk("dir_data_y", 32'(y), 32'h7);

    // 3. scan mode with y_ready held high
    din = 16'h4321; y_ready = 1'b1; mode = 1'b1;
    tick();
    chk("scan_entry_valid", 32'(vld), 32'h0);
    chk("scan_entry_yhold", 32'(y),   32'h7);
    for (int k = 0; k < 5; k++) begin
      tick(); tick();
      chk("scan_gap_valid", 32'(vld), 32'h0);
      tick();
      chk("scan_valid", 32'(vld), 32'h1);
      chk("scan_ch",    32'(ch),  32'(k % 4));
      chk("scan_y",     32'(y),   32'(k % 4 + 1));
    end

    // 4. stall after the first sample, then one transfer
    mode = 1'b0;
    tick();
    chk("dir_entry_valid", 32'(vld), 32'h0);
    mode = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("st_first_valid", 32'(vld), 32'h1);
    chk("st_first_y",     32'(y),   32'h1);
    y_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_hold", {25'd0, vld, ch, y}, {25'd0, 1'b1, 2'd0, 4'h1});
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk("st_next", {25'd0, vld, ch, y}, {25'd0, 1'b1, 2'd1, 4'h2});

    // 5. freeze mid-dwell
    y_ready = 1'b1;
    tick();
    chk("fz_pre_valid", 32'(vld), 32'h0);
    enb_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fz_oe",   32'(oe), 32'h0);
      chk("fz_hold", {25'd0, vld, ch, y}, {25'd0, 1'b0, 2'd1, 4'h2});
    end
    enb_n = 1'b0;
    tick();
    chk("fz_re_oe",    32'(oe),  32'h1);
    chk("fz_re_valid", 32'(vld), 32'h0);
    tick();
    chk("fz_next", {25'd0, vld, ch, y}, {25'd0, 1'b1, 2'd2, 4'h3});

    // 6. async reset pulse between edges
    tick();
    #3 reset = 1'b1;
    #1;
    chk("ar_y",     32'(y),   32'h0);
    chk("ar_oe",    32'(oe),  32'h0);
    chk("ar_ch",    32'(ch),  32'h0);
    chk("ar_valid", 32'(vld), 32'h0);
    #1 reset = 1'b0;
    tick();
    chk("ar_rel_oe",  32'(oe),  32'h1);
    chk("ar_rel_v1",  32'(vld), 32'h0);
    tick();
    chk("ar_rel_v2",  32'(vld), 32'h0);
    tick();
    chk("ar_first", {25'd0, vld, ch, y}, {25'd0, 1'b1, 2'd0, 4'h1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
